// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared lane constants and scheduler state encoding
// Purpose: lane count, lane bit positions and the note scheduler state type.
package ddr_pkg;

    localparam int LANES = 4;

    // Bit positions of each lane inside pattern words and spawn vectors.
    localparam int LANE_L = 3;
    localparam int LANE_U = 2;
    localparam int LANE_D = 1;
    localparam int LANE_R = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        DONE
    } sched_state_e;

endpackage

// File: rtl/note_scheduler_step_timer.sv
// rtl/note_scheduler_step_timer.sv - frame counter producing step boundaries
// Purpose: counts frame_i pulses while enabled and flags every FRAMES_PER_STEP-th
// one as a step boundary; step_due remembers a boundary until it is consumed.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   frame_i       : one-cycle frame pulse
//   en_i          : count frames (scheduler busy)
//   clr_i         : restart counter and drop any pending step_due
//   due_clr_i     : the boundary has been consumed; clear step_due
//   boundary_o    : combinational, this frame_i closes the current step
//   due_o         : a boundary occurred and has not yet been consumed
module step_timer #(
    parameter int FRAMES_PER_STEP = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic due_clr_i,
    output logic boundary_o,
    output logic due_o
);

    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    logic [CW-1:0] cnt;

    assign boundary_o = en_i & frame_i & (cnt == CW'(FRAMES_PER_STEP - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            due_o <= 1'b0;
        end else if (clr_i) begin
            cnt   <= '0;
            due_o <= 1'b0;
        end else begin
            if (en_i && frame_i) begin
                cnt <= boundary_o ? '0 : cnt + 1'b1;
            end
            // Consumption wins: a boundary seen in the expiry cycle is that expiry.
            if (due_clr_i) begin
                due_o <= 1'b0;
            end else if (boundary_o) begin
                due_o <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - pattern-driven arrow spawn sequencer for four lanes
// Purpose: fetches one pattern word per step, offers each set lane as a spawn
// request until it is accepted or the step expires, and counts the notes that
// expired unlaunched.
// Ports:
//   clk_i, rst_ni            : pixel clock, asynchronous active-low reset
//   frame_i                  : frame pulse; FRAMES_PER_STEP pulses per step
//   start_i, stop_i, loop_i  : run control (stop has priority), wrap enable
//   pat_rd_o, pat_addr_o     : pattern read strobe and address
//   pat_data_i               : pattern word, one cycle after pat_rd_o
//   spawn_valid_o/ready_i    : per-lane spawn handshake
//   step_o, busy_o, done_o   : current step and run status
//   drop_cnt_o               : saturating count of expired notes
module note_scheduler
    import ddr_pkg::*;
#(
    parameter int STEPS           = 16,
    parameter int FRAMES_PER_STEP = 15,
    parameter int STEPW           = $clog2(STEPS),
    parameter int DROPW           = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             frame_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             loop_i,
    output logic             pat_rd_o,
    output logic [STEPW-1:0] pat_addr_o,
    input  logic [LANES-1:0] pat_data_i,
    output logic [LANES-1:0] spawn_valid_o,
    input  logic [LANES-1:0] spawn_ready_i,
    output logic [STEPW-1:0] step_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [DROPW-1:0] drop_cnt_o
);

    localparam int CNTW = $clog2(LANES + 1);
    localparam int SUMW = DROPW + 1;

    function automatic logic [CNTW-1:0] popcount(input logic [LANES-1:0] v);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            c = c + CNTW'(v[i]);
        end
        return c;
    endfunction

    sched_state_e     state;
    logic [LANES-1:0] pending;
    logic             boundary;
    logic             step_due;
    logic             expire;
    logic             last_step;
    logic [STEPW-1:0] next_step;
    logic [LANES-1:0] handshake;
    logic [SUMW-1:0]  drop_sum;
    logic [DROPW-1:0] drop_next;
    logic             run_clr;

    assign run_clr   = start_i & ~stop_i & ((state == IDLE) | (state == DONE));
    assign expire    = (state == ISSUE) & (step_due | boundary);
    assign last_step = (step_o == STEPW'(STEPS - 1));
    assign next_step = last_step ? '0 : step_o + 1'b1;
    assign handshake = spawn_valid_o & spawn_ready_i;
    // A lane accepted in the expiry cycle counts as launched, not dropped.
    assign drop_sum  = {1'b0, drop_cnt_o} + SUMW'(popcount(pending & ~handshake));
    assign drop_next = drop_sum[DROPW] ? '1 : drop_sum[DROPW-1:0];

    step_timer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_step_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .frame_i   (frame_i),
        .en_i      ((state == FETCH) | (state == LATCH) | (state == ISSUE)),
        .clr_i     (run_clr),
        .due_clr_i (expire),
        .boundary_o(boundary),
        .due_o     (step_due)
    );

    // spawn_valid_o is kept as an exact registered copy of pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            pending       <= '0;
            spawn_valid_o <= '0;
            pat_rd_o      <= 1'b0;
            pat_addr_o    <= '0;
            step_o        <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            drop_cnt_o    <= '0;
        end else if (stop_i) begin
            state         <= IDLE;
            pending       <= '0;
            spawn_valid_o <= '0;
            pat_rd_o      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        state      <= FETCH;
                        step_o     <= '0;
                        pat_addr_o <= '0;
                        pat_rd_o   <= 1'b1;
                        drop_cnt_o <= '0;
                        busy_o     <= 1'b1;
                        done_o     <= 1'b0;
                    end
                end
                FETCH: begin
                    pat_rd_o <= 1'b0;
                    state    <= LATCH;
                end
                LATCH: begin
                    pending       <= pat_data_i;
                    spawn_valid_o <= pat_data_i;
                    state         <= ISSUE;
                end
                ISSUE: begin
                    if (expire) begin
                        drop_cnt_o    <= drop_next;
                        pending       <= '0;
                        spawn_valid_o <= '0;
                        if (last_step && !loop_i) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            step_o     <= next_step;
                            pat_addr_o <= next_step;
                            pat_rd_o   <= 1'b1;
                        end
                    end else begin
                        pending       <= pending & ~handshake;
                        spawn_valid_o <= pending & ~handshake;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
